// File: rtl/sumres_scan_display_pkg.sv
// Shared constants for the add/subtract result display: FSM encoding,
// active-low 7-segment codes and the result-width helper.
package sumres_scan_display_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_CONV = 2'd2;
    localparam logic [1:0] ST_LOAD = 2'd3;

    // Segment order {g,f,e,d,c,b,a}, a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // A sum of two WIDTH-bit operands needs one extra bit for the carry.
    function automatic int res_width(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/sumres_scan_display_bcd_seg_decode.sv
// One BCD digit to active-low 7-segment pattern; codes above 9 and the
// blank request both turn every segment off.
module bcd_seg_decode
    import sumres_scan_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sumres_scan_display.sv
// Add / absolute-subtract of two operands, sequential binary-to-BCD
// conversion and a multiplexed 7-segment display with leading-zero blanking.
//   state | meaning
//   IDLE  | waiting for start; operands latched when it arrives
//   CALC  | sum or |a-b| and sign computed into the shift register
//   CONV  | WIDTH+1 shift-add-3 steps into the BCD shadow
//   LOAD  | shadow and sign copied to the display, done pulsed
module sumres_scan_display
    import sumres_scan_display_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIGITS    = 3,
    parameter int DIV_LIMIT = 100,
    parameter bit BLANK_LZ  = 1'b1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic              op,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              sign0,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig_en
);

    localparam int RES_W = res_width(WIDTH);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(RES_W);
    localparam int PRE_W = (DIV_LIMIT > 0) ? $clog2(DIV_LIMIT + 1) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q, b_q;
    logic             op_q;
    logic [RES_W-1:0] res_sh, res_calc;
    logic             sign_calc, sign_nxt;
    logic [BCD_W-1:0] bcd_sh, bcd_adj, disp;
    logic [CNT_W-1:0] bit_cnt;
    logic [PRE_W-1:0] presc;
    logic [IDX_W-1:0] idx;
    logic [3:0]       cur_digit;
    logic             upper_zero, blank;

    assign busy = (state != ST_IDLE);

    always_comb begin
        res_calc = RES_W'(a_q) + RES_W'(b_q);
        sign_nxt = 1'b1;
        if (op_q) begin
            if (a_q >= b_q) begin
                res_calc = RES_W'(a_q - b_q);
            end else begin
                res_calc = RES_W'(b_q - a_q);
                sign_nxt = 1'b0;
            end
        end
    end

    // Digits of 5 or more get +3 before the shift so they carry correctly.
    always_comb begin
        bcd_adj = bcd_sh;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sh[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            res_sh    <= '0;
            sign_calc <= 1'b1;
            bcd_sh    <= '0;
            bit_cnt   <= '0;
            disp      <= '0;
            sign0     <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        op_q  <= op;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    res_sh    <= res_calc;
                    sign_calc <= sign_nxt;
                    bcd_sh    <= '0;
                    bit_cnt   <= CNT_W'(WIDTH);
                    state     <= ST_CONV;
                end
                ST_CONV: begin
                    bcd_sh <= {bcd_adj[BCD_W-2:0], res_sh[RES_W-1]};
                    res_sh <= res_sh << 1;
                    if (bit_cnt == '0) begin
                        state <= ST_LOAD;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                ST_LOAD: begin
                    disp  <= bcd_sh;
                    sign0 <= sign_calc;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            idx    <= '0;
            dig_en <= DIGITS'(1);
        end else if (presc == PRE_W'(DIV_LIMIT)) begin
            presc  <= '0;
            dig_en <= (dig_en << 1) | (dig_en >> (DIGITS - 1));
            if (idx == IDX_W'(DIGITS - 1)) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A digit is blanked when it and every more significant digit are zero.
    always_comb begin
        cur_digit  = 4'd0;
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == idx) begin
                cur_digit = disp[4*i +: 4];
            end
            if ((i >= int'(idx)) && (disp[4*i +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
        blank = BLANK_LZ && (idx != '0) && upper_zero;
    end

    bcd_seg_decode u_dec (
        .bcd   (cur_digit),
        .blank (blank),
        .seg   (seg)
    );

endmodule

// File: tb/tb_sumres_scan_display.sv
// Self-checking bench for sumres_scan_display: directed table, random
// operations against an arithmetic model, scan timing, busy and reset cases.
module tb_sumres_scan_display;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] in_a   = '0;
    logic [7:0] in_b   = '0;
    logic       op     = 1'b0;
    logic       start  = 1'b0;
    logic       busy, done, sign0;
    logic [6:0] seg;
    logic [2:0] dig_en;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         a;
        int         b;
        bit         op;
        logic [6:0] s0;
        logic [6:0] s1;
        logic [6:0] s2;
        bit         sg;
    } vec_t;

    vec_t       vecs[9];
    logic [6:0] segtab[10];
    logic [6:0] seen[3];
    bit         got[3];

    sumres_scan_display #(
        .WIDTH     (8),
        .DIGITS    (3),
        .DIV_LIMIT (3),
        .BLANK_LZ  (1'b1)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .in_a   (in_a),
        .in_b   (in_b),
        .op     (op),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .sign0  (sign0),
        .seg    (seg),
        .dig_en (dig_en)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int v, input int i);
        int p = 1;
        repeat (i) p = p * 10;
        if (i > 0 && v < p) return 7'h7F;
        return segtab[(v / p) % 10];
    endfunction

    // Launch one operation and measure edges from the sampling edge to done.
    task automatic run_op(input int a, input int b, input bit o, output int lat);
        bit seen_done = 0;
        @(negedge clk_in);
        in_a  = 8'(a);
        in_b  = 8'(b);
        op    = o;
        start = 1'b1;
        @(posedge clk_in);
        #1 start = 1'b0;
        lat = 0;
        while (lat < 40 && !seen_done) begin
            @(posedge clk_in);
            lat++;
            #1;
            if (lat == 1) check("busy_in_calc", int'(busy), 1);
            if (done) seen_done = 1;
        end
        @(posedge clk_in);
        #1 check("done_one_cycle", int'(done), 0);
    endtask

    task automatic collect();
        for (int i = 0; i < 3; i++) got[i] = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk_in);
            #1;
            case (dig_en)
                3'b001: begin seen[0] = seg; got[0] = 1; end
                3'b010: begin seen[1] = seg; got[1] = 1; end
                3'b100: begin seen[2] = seg; got[2] = 1; end
                default: ;
            endcase
        end
    endtask

    task automatic check_disp(input string tag, input logic [6:0] e0,
                              input logic [6:0] e1, input logic [6:0] e2,
                              input bit esg);
        check({tag, "_sign0"}, int'(sign0), int'(esg));
        collect();
        check({tag, "_seg_units"}, got[0] ? int'(seen[0]) : -1, int'(e0));
        check({tag, "_seg_tens"},  got[1] ? int'(seen[1]) : -1, int'(e1));
        check({tag, "_seg_hund"},  got[2] ? int'(seen[2]) : -1, int'(e2));
    endtask

    initial begin
        int lat, ndone, a, b, v;
        bit o, sg;

        segtab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

        vecs[0] = '{200, 55,  1'b0, 7'h12, 7'h12, 7'h24, 1'b1};
        vecs[1] = '{255, 255, 1'b0, 7'h40, 7'h79, 7'h12, 1'b1};
        vecs[2] = '{10,  250, 1'b1, 7'h40, 7'h19, 7'h24, 1'b0};
        vecs[3] = '{250, 10,  1'b1, 7'h40, 7'h19, 7'h24, 1'b1};
        vecs[4] = '{7,   7,   1'b1, 7'h40, 7'h7F, 7'h7F, 1'b1};
        vecs[5] = '{5,   0,   1'b0, 7'h12, 7'h7F, 7'h7F, 1'b1};
        vecs[6] = '{100, 0,   1'b0, 7'h40, 7'h40, 7'h79, 1'b1};
        vecs[7] = '{3,   12,  1'b1, 7'h10, 7'h7F, 7'h7F, 1'b0};
        vecs[8] = '{60,  0,   1'b1, 7'h40, 7'h02, 7'h7F, 1'b1};

        #12;
        check("rst_busy",   int'(busy),   0);
        check("rst_done",   int'(done),   0);
        check("rst_sign0",  int'(sign0),  1);
        check("rst_dig_en", int'(dig_en), 1);
        check("rst_seg",    int'(seg),    'h40);

        @(negedge clk_in);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk_in);
            #1 check($sformatf("scan_k%0d", k), int'(dig_en), 1 << ((k / 4) % 3));
        end

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat);
            check($sformatf("vec%0d_latency", i), lat, 11);
            check_disp($sformatf("vec%0d", i), vecs[i].s0, vecs[i].s1,
                       vecs[i].s2, vecs[i].sg);
        end

        for (int r = 0; r < 20; r++) begin
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            o  = 1'($urandom_range(0, 1));
            v  = o ? ((a >= b) ? a - b : b - a) : a + b;
            sg = !(o && a < b);
            run_op(a, b, o, lat);
            check($sformatf("rnd%0d_latency", r), lat, 11);
            check_disp($sformatf("rnd%0d", r), exp_seg(v, 0), exp_seg(v, 1),
                       exp_seg(v, 2), sg);
        end

        // Second start while busy must be dropped.
        @(negedge clk_in);
        in_a = 8'd200; in_b = 8'd55; op = 1'b0; start = 1'b1;
        @(posedge clk_in);
        #1 start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk_in);
            #1;
            if (done) ndone++;
            if (k == 3) begin
                in_a = 8'd1; in_b = 8'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("busy_ignore_done_count", ndone, 1);
        check_disp("busy_ignore", 7'h12, 7'h12, 7'h24, 1'b1);

        // Reset during conversion discards the partial result.
        run_op(10, 250, 1'b1, lat);
        check("pre_reset_sign0", int'(sign0), 0);
        @(negedge clk_in);
        in_a = 8'd99; in_b = 8'd1; op = 1'b0; start = 1'b1;
        @(posedge clk_in);
        #1 start = 1'b0;
        repeat (5) @(posedge clk_in);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy",   int'(busy),   0);
        check("midrst_sign0",  int'(sign0),  1);
        check("midrst_dig_en", int'(dig_en), 1);
        check("midrst_seg",    int'(seg),    'h40);
        @(negedge clk_in);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk_in);
            #1 if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        check_disp("midrst", 7'h40, 7'h7F, 7'h7F, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
